// File: rtl/rv32i_types.sv
// Shared types for the rv32i memory hierarchy: word/line types, line geometry
// and the cacheline adapter state encoding.
package rv32i_types;

  typedef logic [31:0]  rv32i_word;
  typedef logic [255:0] cacheline_t;

  localparam int LINE_BYTES  = 32;
  localparam int BURST_BEATS = 4;

  typedef enum logic [1:0] {
    IDLE,
    RD_BURST,
    WR_BURST,
    DONE
  } adapter_state_t;

endpackage

// File: rtl/cacheline_adapter.sv
// Converts one cacheline read/write from the arbiter into a BEATS-long burst
// on the main-memory bus and pulses line_resp once the whole line has moved.
module cacheline_adapter
  import rv32i_types::*;
#(
  parameter int LINE_WIDTH = 256,
  parameter int BEAT_WIDTH = 64,
  parameter int BEATS      = LINE_WIDTH / BEAT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  line_read,
  input  logic                  line_write,
  input  rv32i_word             line_address,
  input  logic [LINE_WIDTH-1:0] line_wdata,
  output logic [LINE_WIDTH-1:0] line_rdata,
  output logic                  line_resp,
  output logic                  burst_read,
  output logic                  burst_write,
  output rv32i_word             burst_address,
  output logic [BEAT_WIDTH-1:0] burst_wdata,
  input  logic [BEAT_WIDTH-1:0] burst_rdata,
  input  logic                  burst_resp
);

  localparam int            CW        = $clog2(BEATS);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  adapter_state_t        state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  rv32i_word             addr_q, addr_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
  logic [LINE_WIDTH-1:0] rdata_q, rdata_d;
  rv32i_word             aligned_addr;

  assign aligned_addr  = line_address & ~rv32i_word'(LINE_BYTES - 1);
  assign burst_address = addr_q;
  assign line_rdata    = rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    burst_read  = 1'b0;
    burst_write = 1'b0;
    burst_wdata = '0;
    line_resp   = 1'b0;

    case (state_q)
      IDLE: begin
        // A simultaneous read+write is illegal; the write takes priority.
        if (line_write) begin
          addr_d  = aligned_addr;
          wdata_d = line_wdata;
          cnt_d   = '0;
          state_d = WR_BURST;
        end else if (line_read) begin
          addr_d  = aligned_addr;
          cnt_d   = '0;
          state_d = RD_BURST;
        end
      end

      RD_BURST: begin
        burst_read = 1'b1;
        if (burst_resp) begin
          rdata_d[int'(cnt_q)*BEAT_WIDTH +: BEAT_WIDTH] = burst_rdata;
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      WR_BURST: begin
        burst_write = 1'b1;
        burst_wdata = wdata_q[int'(cnt_q)*BEAT_WIDTH +: BEAT_WIDTH];
        if (burst_resp) begin
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      DONE: begin
        line_resp = 1'b1;
        cnt_d     = '0;
        state_d   = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cacheline_adapter.sv
// Scoreboard bench for cacheline_adapter: stimulus pushes expected line
// responses and write beats; a negedge monitor pops and compares them.
module tb_cacheline_adapter;
  import rv32i_types::*;

  typedef struct {
    cacheline_t line;
    int         cyc;
  } resp_item_t;

  logic        clk;
  logic        rst_n;
  logic        line_read;
  logic        line_write;
  rv32i_word   line_address;
  cacheline_t  line_wdata;
  cacheline_t  line_rdata;
  logic        line_resp;
  logic        burst_read;
  logic        burst_write;
  rv32i_word   burst_address;
  logic [63:0] burst_wdata;
  logic [63:0] burst_rdata;
  logic        burst_resp;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          expKind = 0;
  rv32i_word   expAddr = '0;
  cacheline_t  modelRdata = '0;
  resp_item_t  respQ[$];
  logic [63:0] wbeatQ[$];

  cacheline_adapter #(
    .LINE_WIDTH(256),
    .BEAT_WIDTH(64),
    .BEATS(4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .line_read    (line_read),
    .line_write   (line_write),
    .line_address (line_address),
    .line_wdata   (line_wdata),
    .line_rdata   (line_rdata),
    .line_resp    (line_resp),
    .burst_read   (burst_read),
    .burst_write  (burst_write),
    .burst_address(burst_address),
    .burst_wdata  (burst_wdata),
    .burst_rdata  (burst_rdata),
    .burst_resp   (burst_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic failNow(input string name, input string what);
    checks++;
    errors++;
    $display("[TB] FAIL %s: %s", name, what);
  endtask

  // Drives one request, then the burst_resp pattern given as a string of
  // '1'/'0' characters, ending in the IDLE cycle after DONE.
  task automatic applyStimulus(input logic rd, input logic wr, input rv32i_word addr,
                               input cacheline_t wline, input cacheline_t rline,
                               input string pat);
    int beat;
    beat         = 0;
    line_read    = rd;
    line_write   = wr;
    line_address = addr;
    line_wdata   = wline;
    expAddr      = addr & 32'hFFFF_FFE0;
    if (wr) begin
      for (int b = 0; b < BURST_BEATS; b++) wbeatQ.push_back(wline[b*64 +: 64]);
    end else begin
      modelRdata = rline;
    end
    respQ.push_back('{line: modelRdata, cyc: cyc + 1 + pat.len()});
    @(posedge clk); #1;
    expKind      = wr ? 2 : 1;
    line_address = 32'hFFFF_FFFF;
    line_wdata   = '1;
    for (int i = 0; i < pat.len(); i++) begin
      burst_resp  = (pat[i] == "1");
      burst_rdata = burst_resp ? rline[beat*64 +: 64] : 64'hDEAD_BEEF_DEAD_BEEF;
      @(posedge clk); #1;
      if (burst_resp) beat++;
    end
    burst_resp  = 1'b0;
    burst_rdata = '0;
    expKind     = 0;
    line_read   = 1'b0;
    line_write  = 1'b0;
    @(posedge clk); #1;
  endtask

  // Monitor: burst handshake shape every cycle, write beats and line responses
  // against the queues filled by the stimulus.
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("burst_read", burst_read, expKind == 1);
      checkOutput("burst_write", burst_write, expKind == 2);
      if (burst_read || burst_write) checkOutput("burst_address", burst_address, expAddr);
      if (burst_write) begin
        if (wbeatQ.size() == 0) begin
          failNow("burst_wdata", "write beat with no expected beat queued");
        end else begin
          checkOutput("burst_wdata", burst_wdata, wbeatQ[0]);
          if (burst_resp) void'(wbeatQ.pop_front());
        end
      end
      if (line_resp) begin
        if (respQ.size() == 0) begin
          failNow("line_resp", "unexpected completion pulse");
        end else begin
          resp_item_t item;
          item = respQ.pop_front();
          checkOutput("line_rdata", line_rdata, item.line);
          checkOutput("resp_cycle", cyc, item.cyc);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    cacheline_t rline1, wline2, wline3, wline4, rline5;
    rline1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    wline2 = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
              64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    wline3 = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
              64'h5555_0000_5555_0000, 64'h0F0F_0F0F_F0F0_F0F0};
    wline4 = {64'h9999_8888_7777_6666, 64'h1234_1234_1234_1234,
              64'hCAFE_F00D_CAFE_F00D, 64'h0000_0000_0000_0001};
    rline5 = {64'h0404_0404_0404_0404, 64'h0303_0303_0303_0303,
              64'h0202_0202_0202_0202, 64'h0101_0101_0101_0101};

    rst_n        = 1'b1;
    line_read    = 1'b0;
    line_write   = 1'b0;
    line_address = '0;
    line_wdata   = '0;
    burst_rdata  = '0;
    burst_resp   = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset_line_rdata", line_rdata, '0);
    checkOutput("reset_line_resp", line_resp, 1'b0);
    checkOutput("reset_burst_read", burst_read, 1'b0);
    checkOutput("reset_burst_write", burst_write, 1'b0);
    checkOutput("reset_burst_address", burst_address, '0);
    checkOutput("reset_burst_wdata", burst_wdata, '0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Read with consecutive beats, then a write the cycle after line_resp.
    applyStimulus(1'b1, 1'b0, 32'h0000_1234, '0, rline1, "1111");
    applyStimulus(1'b0, 1'b1, 32'h0000_5678, wline2, '0, "1001101");

    // Stray burst_resp while idle must not move the beat counter.
    burst_resp  = 1'b1;
    burst_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    repeat (2) @(posedge clk);
    #1;
    burst_resp = 1'b0;
    applyStimulus(1'b0, 1'b1, 32'h0000_2000, wline3, '0, "1111");

    // Simultaneous read and write: only the write is serviced.
    applyStimulus(1'b1, 1'b1, 32'h0000_3FFF, wline4, '0, "01111");

    // Reset in the middle of a read burst.
    line_read    = 1'b1;
    line_address = 32'h0000_8040;
    expAddr      = 32'h0000_8040;
    @(posedge clk); #1;
    expKind = 1;
    for (int i = 0; i < 2; i++) begin
      burst_resp  = 1'b1;
      burst_rdata = rline1[i*64 +: 64];
      @(posedge clk); #1;
    end
    rst_n      = 1'b0;
    expKind    = 0;
    line_read  = 1'b0;
    burst_resp = 1'b0;
    modelRdata = '0;
    #1;
    checkOutput("midrst_burst_read", burst_read, 1'b0);
    checkOutput("midrst_line_resp", line_resp, 1'b0);
    checkOutput("midrst_line_rdata", line_rdata, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b0, 32'h0000_8047, '0, rline5, "11011");

    repeat (3) @(posedge clk);
    #1;
    checkOutput("resp_pending", respQ.size(), 0);
    checkOutput("wbeat_pending", wbeatQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cacheline_adapter.md
Name: cacheline_adapter

Overview:
Responder for the arbiter's single physical-memory port. Accepts one 256-bit cacheline read or write request at a time from the arbiter and converts it into a 4-beat, 64-bit burst transaction on the main-memory bus. Returns a one-cycle line_resp when the whole line has been transferred. Sits between the arbiter and the memory model or DRAM controller.

Parameters:
LINE_WIDTH, 256, cacheline width in bits; must equal BEATS*BEAT_WIDTH
BEAT_WIDTH, 64, memory data bus width in bits
BEATS, 4, beats per burst; derived as LINE_WIDTH/BEAT_WIDTH

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  reset, asynchronous assert, active-low
line_read  input  1  arbiter requests a line read; held until line_resp
line_write  input  1  arbiter requests a line write; held until line_resp
line_address  input  32  line byte address; bits [4:0] are ignored and driven as 0 downstream
line_wdata  input  LINE_WIDTH  write line data
line_rdata  output  LINE_WIDTH  assembled read line
line_resp  output  1  one-cycle completion pulse
burst_read  output  1  memory read burst request
burst_write  output  1  memory write burst request
burst_address  output  32  line-aligned burst address
burst_wdata  output  BEAT_WIDTH  current write beat
burst_rdata  input  BEAT_WIDTH  current read beat
burst_resp  input  1  memory accepts or returns one beat this cycle

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, beat counter=0, line_rdata=0, line_resp=0.
  - burst_read=0, burst_write=0, burst_address=0, burst_wdata=0.
  - Takes effect immediately, including mid-burst. The in-flight burst is abandoned and no line_resp is issued.
- States: IDLE, RD_BURST, WR_BURST, DONE.
- IDLE:
  - line_write=1 -> latch {line_address[31:5],5'b0} and line_wdata; go to WR_BURST.
  - Else line_read=1 -> latch the address; go to RD_BURST.
  - Both asserted (illegal) -> write wins; the read is not serviced.
- RD_BURST:
  - burst_read=1, burst_address=latched address.
  - On each cycle with burst_resp=1, store burst_rdata into slice [cnt*64 +: 64] and increment cnt.
  - On the beat where cnt==BEATS-1 -> DONE, and burst_read drops in the same edge.
- WR_BURST:
  - burst_write=1, burst_wdata=latched line slice [cnt*64 +: 64].
  - Advance cnt on burst_resp; after the last beat -> DONE.
- Beats:
  - Beat 0 is bits [63:0], beat 3 is bits [255:192].
  - Beats may arrive with idle gaps (burst_resp=0); the adapter holds its state and outputs through gaps.
  - burst_address is constant for the whole burst.
- DONE:
  - line_resp=1 for exactly one cycle; cnt reset to 0; go to IDLE.
  - Request inputs are not sampled in DONE.
  - The next request can be accepted the cycle after DONE, so back-to-back requests have a minimum 1-cycle IDLE gap.
- line_rdata:
  - Valid in the DONE cycle.
  - Holds its value until the next read burst writes beat 0.
  - A write transaction does not alter it.
- Latency: minimum request-to-line_resp = 6 cycles (1 accept + 4 beats + 1 DONE).
- Request changes after accept are ignored until the transaction completes.
- burst_resp outside RD_BURST/WR_BURST is ignored.
- burst_read and burst_write are never asserted together.

Decomposition:
- Add to the shared rv32i_types package:
  - a cacheline_t typedef (logic [255:0]);
  - constants LINE_BYTES=32 and BURST_BEATS=4;
  - the adapter state enum adapter_state_t.
- Reuse rv32i_word for addresses.
- No sub-module is required. The beat counter and the slice mux/demux stay inline in this single module.

Test Plan:
- Read, consecutive beats: line_read=1, line_address=0x0000_1234; memory returns 0x11..11, 0x22..22, 0x33..33, 0x44..44 on 4 consecutive burst_resp cycles -> burst_address=0x0000_1220; line_resp pulses once, 6 cycles after the request; line_rdata={0x44..44, 0x33..33, 0x22..22, 0x11..11}.
- Write with gaps: line_write=1, line_wdata=0xDDDD..CCCC..BBBB..AAAA (beat3..beat0), burst_resp pattern 1,0,0,1,1,0,1 -> burst_wdata sequence AAAA, BBBB, CCCC, DDDD, each beat held across its gap; burst_write drops after the 4th resp; one line_resp.
- Reset mid-burst: assert rst_n=0 after 2 read beats -> burst_read=0 immediately, no line_resp. A fresh read after rst_n=1 collects all 4 beats from beat 0.
- Simultaneous request: line_read=1 and line_write=1 in IDLE -> only burst_write is asserted; burst_read stays 0 throughout.
- Back-to-back: read completes, then line_write is asserted the cycle after line_resp -> write is accepted with exactly 1 IDLE cycle between; line_rdata is unchanged by the write.
- Stray resp: burst_resp=1 while IDLE -> no state change, no line_resp, cnt stays 0.
